// File: rtl/dma_pcie_c2h_byp_dsc_issue.sv
// Credit-gated, strictly in-order issue stage for the QDMA C2H bypass-in port.
// Define C2H_BYP_LEN_CHK_EN to drop zero-length descriptors and flag them on err_len_zero.
module dma_pcie_c2h_byp_dsc_issue #(
    parameter int QID_WIDTH  = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int CRDT_W     = 8,
    parameter int CRDT_INIT  = 0
) (
    input  logic                        user_clk,
    input  logic                        user_reset,
    input  logic [63:0]                 s_dsc,
    input  logic [QID_WIDTH-1:0]        s_qid,
    input  logic [21:0]                 s_len,
    input  logic                        s_last,
    input  logic [1:0]                  s_chn,
    input  logic                        s_vld,
    output logic                        s_rdy,
    output logic [63:0]                 m_dsc,
    output logic [QID_WIDTH-1:0]        m_qid,
    output logic [21:0]                 m_len,
    output logic                        m_last,
    output logic [1:0]                  m_chn,
    output logic                        m_vld,
    input  logic [1:0]                  m_crdt_chn,
    input  logic                        m_crdt,
    output logic [4*CRDT_W-1:0]         crdt_avail,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        err_crdt_ovf,
    output logic                        err_len_zero
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CRDT_W-1:0] CRDT_MAX = {CRDT_W{1'b1}};

    typedef struct packed {
        logic [63:0]          dsc;
        logic [QID_WIDTH-1:0] qid;
        logic [21:0]          len;
        logic                 last;
        logic [1:0]           chn;
    } dsc_t;

    dsc_t                   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            cnt_q, cnt_d;
    logic                   rdy_q;
    logic [3:0][CRDT_W-1:0] crdt_q, crdt_d;
    logic [3:0]             inc_s, dec_s;
    logic                   ovf_s, accept_s, push_s, lz_s, issue_s;
    dsc_t                   head_s, in_s, m_q;
    logic                   m_vld_q, ovf_q, lz_q;

    assign in_s     = {s_dsc, s_qid, s_len, s_last, s_chn};
    assign head_s   = mem_q[rd_ptr_q];
    assign accept_s = s_vld && rdy_q;

`ifdef C2H_BYP_LEN_CHK_EN
    assign push_s = accept_s && (s_len != 22'd0);
    assign lz_s   = accept_s && (s_len == 22'd0);
`else
    assign push_s = accept_s;
    assign lz_s   = 1'b0;
`endif

    // Issue looks only at registered state, so a same-cycle push into an empty FIFO cannot issue.
    assign issue_s = (cnt_q != {(AW+1){1'b0}}) && (crdt_q[head_s.chn] != {CRDT_W{1'b0}});
    assign inc_s   = m_crdt  ? (4'b0001 << m_crdt_chn) : 4'b0000;
    assign dec_s   = issue_s ? (4'b0001 << head_s.chn) : 4'b0000;

    // Per-channel credit update; a return that would wrap is dropped and flagged instead.
    always_comb begin
        crdt_d = crdt_q;
        ovf_s  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (inc_s[c] && !dec_s[c]) begin
                if (crdt_q[c] == CRDT_MAX) begin
                    ovf_s = 1'b1;
                end else begin
                    crdt_d[c] = crdt_q[c] + 1'b1;
                end
            end else if (dec_s[c] && !inc_s[c]) begin
                crdt_d[c] = crdt_q[c] - 1'b1;
            end else begin
                crdt_d[c] = crdt_q[c];
            end
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = push_s  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = issue_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_s, issue_s})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state, credits, registered bypass-in bus and error pulses.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {(AW+1){1'b0}};
            rdy_q    <= 1'b0;
            crdt_q   <= {4{CRDT_W'(CRDT_INIT)}};
            m_q      <= '0;
            m_vld_q  <= 1'b0;
            ovf_q    <= 1'b0;
            lz_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= (cnt_d != (AW+1)'(FIFO_DEPTH));
            crdt_q   <= crdt_d;
            m_vld_q  <= issue_s;
            ovf_q    <= ovf_s;
            lz_q     <= lz_s;
            if (issue_s) begin
                m_q <= head_s;
            end else begin
                m_q <= m_q;
            end
        end
    end

    // Descriptor storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge user_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_s;
        end
    end

    assign s_rdy        = rdy_q;
    assign m_dsc        = m_q.dsc;
    assign m_qid        = m_q.qid;
    assign m_len        = m_q.len;
    assign m_last       = m_q.last;
    assign m_chn        = m_q.chn;
    assign m_vld        = m_vld_q;
    assign crdt_avail   = crdt_q;
    assign fifo_cnt     = cnt_q;
    assign err_crdt_ovf = ovf_q;
    assign err_len_zero = lz_q;
endmodule

// File: tb/tb_dma_pcie_c2h_byp_dsc_issue.sv
// Randomized bench for the C2H bypass issue stage against a queue-based reference model.
module tb_dma_pcie_c2h_byp_dsc_issue;
    localparam int QW = 12, DEPTH = 16, CW = 8, CINIT = 0;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [63:0]   dsc;
        logic [QW-1:0] qid;
        logic [21:0]   len;
        logic          last;
        logic [1:0]    chn;
    } d_t;
    typedef struct packed {
        logic [31:0] cyc;
        d_t          d;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          user_reset = 1'b1;
    logic [63:0]   s_dsc = 64'd0;
    logic [QW-1:0] s_qid = '0;
    logic [21:0]   s_len = 22'd0;
    logic          s_last = 1'b0, s_vld = 1'b0, m_crdt = 1'b0;
    logic [1:0]    s_chn = 2'd0, m_crdt_chn = 2'd0;
    logic          s_rdy, m_last, m_vld, err_crdt_ovf, err_len_zero;
    logic [63:0]   m_dsc;
    logic [QW-1:0] m_qid;
    logic [21:0]   m_len;
    logic [1:0]    m_chn;
    logic [4*CW-1:0] crdt_avail;
    logic [4:0]      fifo_cnt;

    dma_pcie_c2h_byp_dsc_issue #(.QID_WIDTH(QW), .FIFO_DEPTH(DEPTH), .CRDT_W(CW), .CRDT_INIT(CINIT)) dut (
        .user_clk(clk), .user_reset(user_reset),
        .s_dsc(s_dsc), .s_qid(s_qid), .s_len(s_len), .s_last(s_last), .s_chn(s_chn),
        .s_vld(s_vld), .s_rdy(s_rdy),
        .m_dsc(m_dsc), .m_qid(m_qid), .m_len(m_len), .m_last(m_last), .m_chn(m_chn), .m_vld(m_vld),
        .m_crdt_chn(m_crdt_chn), .m_crdt(m_crdt),
        .crdt_avail(crdt_avail), .fifo_cnt(fifo_cnt),
        .err_crdt_ovf(err_crdt_ovf), .err_len_zero(err_len_zero)
    );

    int errs = 0, checks = 0;

    // Reference model: a descriptor queue and four integer credit pools, stepped once per edge.
    d_t  mq[$];
    int  cr[4];
    int  mcyc = 0;
    bit  m_rdy = 1'b0, m_iss;
    d_t  m_h, m_in;
    ev_t m_ev, mon_ev;
    ev_t exp_log[$], dut_log[$];
    int  exp_ovf_n = 0, dut_ovf_n = 0, exp_lz_n = 0, dut_lz_n = 0;

    always @(posedge clk) begin
        mcyc++;
        if (user_reset) begin
            mq.delete();
            for (int c = 0; c < 4; c++) cr[c] = CINIT;
            m_rdy = 1'b0;
        end else begin
            m_iss = (mq.size() > 0) && (cr[mq[0].chn] > 0);
            if (m_iss) begin
                m_h = mq.pop_front();
                cr[m_h.chn]--;
                m_ev.cyc = 32'(mcyc);
                m_ev.d   = m_h;
                exp_log.push_back(m_ev);
            end
            if (m_crdt) begin
                if (cr[m_crdt_chn] == CMAX) exp_ovf_n++;
                else cr[m_crdt_chn]++;
            end
            if (s_vld && m_rdy) begin
                m_in = {s_dsc, s_qid, s_len, s_last, s_chn};
`ifdef C2H_BYP_LEN_CHK_EN
                if (s_len == 22'd0) exp_lz_n++;
                else mq.push_back(m_in);
`else
                mq.push_back(m_in);
`endif
            end
            m_rdy = (mq.size() != DEPTH);
        end
    end

    // Output monitor: records every issued descriptor and error pulse with its cycle stamp.
    always @(negedge clk) begin
        if (m_vld === 1'b1) begin
            mon_ev.cyc = 32'(mcyc);
            mon_ev.d   = {m_dsc, m_qid, m_len, m_last, m_chn};
            dut_log.push_back(mon_ev);
        end
        if (err_crdt_ovf === 1'b1) dut_ovf_n++;
        if (err_len_zero === 1'b1) dut_lz_n++;
    end

    function automatic int log_diffs();
        int n = 0;
        if (dut_log.size() != exp_log.size()) n++;
        for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++)
            if (dut_log[i] !== exp_log[i]) n++;
        return n;
    endfunction

    function automatic logic [4*CW-1:0] model_crdt();
        logic [4*CW-1:0] r;
        for (int c = 0; c < 4; c++) r[c*CW +: CW] = CW'(cr[c]);
        return r;
    endfunction

    function automatic int crd(int c);
        return int'(crdt_avail[c*CW +: CW]);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [1:0] ch, input logic [21:0] len, output d_t d);
        d.dsc = {$urandom, $urandom};
        d.qid = QW'($urandom);
        d.len = len;
        d.last = 1'($urandom);
        d.chn = ch;
        {s_dsc, s_qid, s_len, s_last, s_chn} = d;
    endtask

    task automatic push_one(input logic [1:0] ch, input logic [21:0] len, output d_t d);
        @(negedge clk);
        set_fields(ch, len, d);
        s_vld = 1'b1;
        @(negedge clk);
        s_vld = 1'b0;
    endtask

    task automatic credit_one(input logic [1:0] ch);
        @(negedge clk);
        m_crdt_chn = ch;
        m_crdt = 1'b1;
        @(negedge clk);
        m_crdt = 1'b0;
    endtask

    task automatic test_reset();
        user_reset = 1'b1;
        idle(3);
        checks++; if (s_rdy !== 1'b0) begin errs++; $display("FAIL rst_rdy_asserted: got %b want 0", s_rdy); end
        checks++; if (m_vld !== 1'b0) begin errs++; $display("FAIL rst_mvld: got %b want 0", m_vld); end
        user_reset = 1'b0;
        idle(1);
        checks++; if (s_rdy !== 1'b1) begin errs++; $display("FAIL rst_rdy_after: got %b want 1", s_rdy); end
        checks++; if (fifo_cnt !== 5'd0) begin errs++; $display("FAIL rst_cnt: got %0d want 0", fifo_cnt); end
        checks++; if (crdt_avail !== {4{CW'(CINIT)}}) begin errs++; $display("FAIL rst_crdt: got %h want %h", crdt_avail, {4{CW'(CINIT)}}); end
        checks++; if ({m_dsc, m_qid, m_len, m_last, m_chn, err_crdt_ovf, err_len_zero} !== '0) begin
            errs++; $display("FAIL rst_outputs: got %h want 0", {m_dsc, m_qid, m_len, m_last, m_chn, err_crdt_ovf, err_len_zero}); end
    endtask

    task automatic test_first_credit();
        d_t d0;
        int n;
        push_one(2'd2, 22'd64, d0);
        idle(4);
        checks++; if (dut_log.size() !== 0) begin errs++; $display("FAIL nocredit_issue: got %0d issues want 0", dut_log.size()); end
        @(negedge clk);
        m_crdt_chn = 2'd2; m_crdt = 1'b1;
        @(posedge clk); #1 n = mcyc;
        @(negedge clk);
        m_crdt = 1'b0;
        idle(3);
        checks++; if (dut_log.size() !== 1) begin errs++; $display("FAIL credit_issue_cnt: got %0d want 1", dut_log.size()); end
        else begin
            checks++; if (dut_log[0].cyc !== 32'(n + 1)) begin errs++; $display("FAIL credit_latency: got cyc %0d want %0d", dut_log[0].cyc, n + 1); end
            checks++; if (dut_log[0].d !== d0) begin errs++; $display("FAIL credit_fields: got %h want %h", dut_log[0].d, d0); end
        end
        checks++; if (crd(2) !== 0) begin errs++; $display("FAIL credit_chn2_end: got %0d want 0", crd(2)); end
        checks++; if (log_diffs() !== 0) begin errs++; $display("FAIL first_model: got %0d diffs want 0", log_diffs()); end
    endtask

    task automatic test_back_to_back();
        d_t sent[6];
        int base = dut_log.size();
        repeat (4) credit_one(2'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_fields(2'd0, 22'($urandom_range(1, 4096)), sent[i]);
            s_vld = 1'b1;
        end
        @(negedge clk);
        s_vld = 1'b0;
        idle(6);
        checks++; if (dut_log.size() - base !== 4) begin errs++; $display("FAIL b2b_first_burst: got %0d want 4", dut_log.size() - base); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (dut_log[base+i].d !== sent[i]) begin errs++; $display("FAIL b2b_order[%0d]: got %h want %h", i, dut_log[base+i].d, sent[i]); end
            if (i > 0) begin
                checks++; if (dut_log[base+i].cyc !== dut_log[base+i-1].cyc + 32'd1) begin
                    errs++; $display("FAIL b2b_gap[%0d]: got cyc %0d want %0d", i, dut_log[base+i].cyc, dut_log[base+i-1].cyc + 32'd1); end
            end
        end
        checks++; if (fifo_cnt !== 5'd2) begin errs++; $display("FAIL b2b_stall_cnt: got %0d want 2", fifo_cnt); end
        repeat (2) credit_one(2'd0);
        idle(4);
        checks++; if (dut_log.size() - base !== 6) begin errs++; $display("FAIL b2b_total: got %0d want 6", dut_log.size() - base); end
        else begin
            checks++; if ({dut_log[base+4].d, dut_log[base+5].d} !== {sent[4], sent[5]}) begin
                errs++; $display("FAIL b2b_tail: got %h want %h", {dut_log[base+4].d, dut_log[base+5].d}, {sent[4], sent[5]}); end
        end
        checks++; if (log_diffs() !== 0) begin errs++; $display("FAIL b2b_model: got %0d diffs want 0", log_diffs()); end
    endtask

    task automatic test_hol();
        d_t a, b;
        int base = dut_log.size();
        repeat (5) credit_one(2'd3);
        push_one(2'd1, 22'd16, a);
        push_one(2'd3, 22'd32, b);
        idle(4);
        checks++; if (dut_log.size() !== base) begin errs++; $display("FAIL hol_blocked: got %0d issues want 0", dut_log.size() - base); end
        credit_one(2'd1);
        idle(4);
        checks++; if (dut_log.size() - base !== 2) begin errs++; $display("FAIL hol_release: got %0d want 2", dut_log.size() - base); end
        else begin
            checks++; if ({dut_log[base].d, dut_log[base+1].d} !== {a, b}) begin errs++; $display("FAIL hol_order: got %h want %h", {dut_log[base].d, dut_log[base+1].d}, {a, b}); end
            checks++; if (dut_log[base+1].cyc !== dut_log[base].cyc + 32'd1) begin errs++; $display("FAIL hol_next_cycle: got %0d want %0d", dut_log[base+1].cyc, dut_log[base].cyc + 32'd1); end
        end
        checks++; if (crd(3) !== 4) begin errs++; $display("FAIL hol_crdt3: got %0d want 4", crd(3)); end
    endtask

    task automatic test_full();
        d_t d;
        int acc = 0;
        @(negedge clk);
        set_fields(2'd1, 22'd100, d);
        s_vld = 1'b1;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (s_rdy) acc++;
            set_fields(2'd1, 22'($urandom_range(1, 999)), d);
            @(negedge clk);
        end
        #1;
        checks++; if (acc !== DEPTH) begin errs++; $display("FAIL full_accepts: got %0d want %0d", acc, DEPTH); end
        checks++; if (s_rdy !== 1'b0) begin errs++; $display("FAIL full_rdy: got %b want 0", s_rdy); end
        checks++; if (fifo_cnt !== 5'd16) begin errs++; $display("FAIL full_cnt: got %0d want 16", fifo_cnt); end
        m_crdt_chn = 2'd1;
        for (int i = 0; i < 6; i++) begin
            m_crdt = (i < 2);
            set_fields(2'd1, 22'($urandom_range(1, 999)), d);
            @(negedge clk); #1;
            checks++; if ({s_rdy, fifo_cnt} !== {m_rdy, 5'(mq.size())}) begin
                errs++; $display("FAIL full_pushpop[%0d]: got rdy %b cnt %0d want rdy %b cnt %0d", i, s_rdy, fifo_cnt, m_rdy, mq.size()); end
        end
        checks++; if (fifo_cnt !== 5'd16) begin errs++; $display("FAIL full_refill: got %0d want 16", fifo_cnt); end
        s_vld = 1'b0;
        repeat (DEPTH) credit_one(2'd1);
        idle(3);
        checks++; if (fifo_cnt !== 5'd0) begin errs++; $display("FAIL full_drain: got %0d want 0", fifo_cnt); end
        checks++; if (log_diffs() !== 0) begin errs++; $display("FAIL full_model: got %0d diffs want 0", log_diffs()); end
    endtask

    task automatic test_saturation();
        d_t d;
        int ovf0 = dut_ovf_n;
        int base = dut_log.size();
        @(negedge clk);
        m_crdt_chn = 2'd0; m_crdt = 1'b1;
        repeat (CMAX + 1) @(negedge clk);
        m_crdt = 1'b0;
        idle(2);
        checks++; if (crd(0) !== CMAX) begin errs++; $display("FAIL sat_value: got %0d want %0d", crd(0), CMAX); end
        checks++; if (dut_ovf_n - ovf0 !== 1) begin errs++; $display("FAIL sat_ovf_pulse: got %0d want 1", dut_ovf_n - ovf0); end
        @(negedge clk);
        set_fields(2'd0, 22'd5, d);
        s_vld = 1'b1;
        @(negedge clk);
        s_vld = 1'b0; m_crdt_chn = 2'd0; m_crdt = 1'b1;
        @(negedge clk);
        m_crdt = 1'b0;
        idle(3);
        checks++; if (crd(0) !== CMAX) begin errs++; $display("FAIL sat_issue_return: got %0d want %0d", crd(0), CMAX); end
        checks++; if (dut_ovf_n - ovf0 !== 1) begin errs++; $display("FAIL sat_no_extra_ovf: got %0d want 1", dut_ovf_n - ovf0); end
        checks++; if (dut_log.size() - base !== 1) begin errs++; $display("FAIL sat_issued: got %0d want 1", dut_log.size() - base); end
    endtask

    task automatic test_len_check();
        d_t a, b;
        int base = dut_log.size();
        int lz0 = dut_lz_n;
        push_one(2'd0, 22'd0, a);
        push_one(2'd0, 22'd8, b);
        idle(4);
`ifdef C2H_BYP_LEN_CHK_EN
        checks++; if (dut_log.size() - base !== 1) begin errs++; $display("FAIL len_issues: got %0d want 1", dut_log.size() - base); end
        else begin
            checks++; if (dut_log[base].d !== b) begin errs++; $display("FAIL len_survivor: got %h want %h", dut_log[base].d, b); end
        end
        checks++; if (dut_lz_n - lz0 !== 1) begin errs++; $display("FAIL len_err_pulse: got %0d want 1", dut_lz_n - lz0); end
`else
        checks++; if (dut_log.size() - base !== 2) begin errs++; $display("FAIL len_issues: got %0d want 2", dut_log.size() - base); end
        else begin
            checks++; if ({dut_log[base].d, dut_log[base+1].d} !== {a, b}) begin errs++; $display("FAIL len_both: got %h want %h", {dut_log[base].d, dut_log[base+1].d}, {a, b}); end
        end
        checks++; if (dut_lz_n - lz0 !== 0) begin errs++; $display("FAIL len_err_pulse: got %0d want 0", dut_lz_n - lz0); end
`endif
    endtask

    task automatic test_random();
        d_t d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_fields(2'($urandom), ($urandom % 4 == 0) ? 22'd0 : 22'($urandom % 1024), d);
            s_vld = 1'($urandom);
            m_crdt = ($urandom % 3 == 0);
            m_crdt_chn = 2'($urandom);
        end
        @(negedge clk);
        s_vld = 1'b0; m_crdt = 1'b0;
        idle(3);
        checks++; if (log_diffs() !== 0) begin errs++; $display("FAIL rand_log: got %0d diffs (dut %0d exp %0d)", log_diffs(), dut_log.size(), exp_log.size()); end
        checks++; if (crdt_avail !== model_crdt()) begin errs++; $display("FAIL rand_crdt: got %h want %h", crdt_avail, model_crdt()); end
        checks++; if (fifo_cnt !== 5'(mq.size())) begin errs++; $display("FAIL rand_cnt: got %0d want %0d", fifo_cnt, mq.size()); end
        checks++; if ({dut_ovf_n, dut_lz_n} !== {exp_ovf_n, exp_lz_n}) begin
            errs++; $display("FAIL rand_errs: got ovf %0d lz %0d want ovf %0d lz %0d", dut_ovf_n, dut_lz_n, exp_ovf_n, exp_lz_n); end
    endtask

    task automatic test_mid_reset();
        d_t d;
        int base;
        repeat (5) credit_one(2'd2);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_fields(2'd1, 22'd40, d);
            s_vld = 1'b1;
        end
        @(negedge clk);
        s_vld = 1'b0;
        user_reset = 1'b1;
        idle(2);
        user_reset = 1'b0;
        idle(1);
        checks++; if ({s_rdy, m_vld, fifo_cnt} !== {1'b1, 1'b0, 5'd0}) begin errs++; $display("FAIL midrst_state: got rdy %b vld %b cnt %0d want 1 0 0", s_rdy, m_vld, fifo_cnt); end
        checks++; if (crdt_avail !== {4{CW'(CINIT)}}) begin errs++; $display("FAIL midrst_crdt: got %h want %h", crdt_avail, {4{CW'(CINIT)}}); end
        base = dut_log.size();
        push_one(2'd2, 22'd12, d);
        idle(4);
        checks++; if (dut_log.size() !== base) begin errs++; $display("FAIL midrst_credit_discarded: got %0d issues want 0", dut_log.size() - base); end
        checks++; if (log_diffs() !== 0) begin errs++; $display("FAIL midrst_model: got %0d diffs want 0", log_diffs()); end
    endtask

    initial begin
        test_reset();
        test_first_credit();
        test_back_to_back();
        test_hol();
        test_full();
        test_saturation();
        test_len_check();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
